// File: rtl/register_file_sb.sv
// Multi-port register file with a pending-write scoreboard: three combinational
// read ports, one write port, a reservation port and a registered busy population count.
module register_file_sb #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned SP_REG  = 31,
  parameter logic [DATA_W-1:0] SP_INIT = 64'h0000_0000_0008_0000,
  parameter bit          BYPASS  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy_rs,
  output logic              busy_rt,
  output logic              busy_rd,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rsv_ok,
  output logic [ADDR_W:0]   busy_count
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;
  logic [ADDR_W:0]     count_next;
  logic                fwd;

  // Forwarding is suppressed during reset so reads show the array as it stands.
  assign fwd = BYPASS && rst_n && wr_en;

  always_comb begin
    rs_data = regs[rs_addr];
    rt_data = regs[rt_addr];
    rd_data = regs[rd_addr];
    if (fwd && (rs_addr == wr_addr)) rs_data = wr_data;
    if (fwd && (rt_addr == wr_addr)) rt_data = wr_data;
    if (fwd && (rd_addr == wr_addr)) rd_data = wr_data;
  end

  assign busy_rs = busy[rs_addr];
  assign busy_rt = busy[rt_addr];
  assign busy_rd = busy[rd_addr];

  // A register being written this cycle may be re-reserved in the same cycle.
  assign rsv_ok = rst_n && rsv_en &&
                  (!busy[rsv_addr] || (wr_en && (wr_addr == rsv_addr)));

  // Clear-on-write is applied before set-on-reserve so set wins on a collision.
  always_comb begin
    busy_next = busy;
    if (wr_en) busy_next[wr_addr] = 1'b0;
    if (rsv_ok) busy_next[rsv_addr] = 1'b1;
    count_next = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      count_next = count_next + (ADDR_W+1)'(busy_next[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      regs[SP_REG] <= SP_INIT;
      busy         <= '0;
      busy_count   <= '0;
    end else begin
      if (wr_en) regs[wr_addr] <= wr_data;
      busy       <= busy_next;
      busy_count <= count_next;
    end
  end

endmodule

// File: doc/register_file_sb.md
REGISTER_FILE_SB -- requirements
Module: register_file_sb

Interface
REQ-001 Parameter: DATA_W, 64, register width in bits.
REQ-002 Parameter: ADDR_W, 5, address width; NUM_REGS = 2**ADDR_W.
REQ-003 Parameter: SP_REG, 31, index of the stack-pointer register.
REQ-004 Parameter: SP_INIT, 64'h0000_0000_0008_0000, reset value of SP_REG.
REQ-005 Parameter: BYPASS, 1, 1 = same-cycle write-to-read forwarding, 0 = none.
REQ-006 One clock; reset is synchronous and active-low.
REQ-007 clk  input  1  rising-edge clock for all state.
REQ-008 rst_n  input  1  synchronous active-low reset.
REQ-009 rs_addr, rt_addr, rd_addr  input  ADDR_W each  read-port addresses.
REQ-010 rs_data, rt_data, rd_data  output  DATA_W each  read-port data.
REQ-011 busy_rs, busy_rt, busy_rd  output  1 each  scoreboard busy bit of the addressed register.
REQ-012 wr_en  input  1  write strobe.
REQ-013 wr_addr  input  ADDR_W  write address.
REQ-014 wr_data  input  DATA_W  write data.
REQ-015 rsv_en  input  1  reservation request: mark a register pending-write.
REQ-016 rsv_addr  input  ADDR_W  register to reserve.
REQ-017 rsv_ok  output  1  reservation accepted this cycle (combinational).
REQ-018 busy_count  output  ADDR_W+1  number of registers currently busy (registered).

Function
REQ-019 Reads SHALL be combinational from the register array on all three ports, independent of one another.
REQ-020 With BYPASS=1, a read port whose address equals wr_addr while wr_en=1 and rst_n=1 SHALL return wr_data in the same cycle; with BYPASS=0 it SHALL return the old value.
REQ-021 On a rising clk edge with rst_n=1 and wr_en=1, array[wr_addr] SHALL take wr_data; the new value is visible on reads from the next cycle.
REQ-022 busy_rs/rt/rd SHALL reflect the registered busy vector, not affected by same-cycle wr_en or rsv_en.
REQ-023 rsv_ok SHALL be 1 iff rsv_en=1 and (busy[rsv_addr]=0 or (wr_en=1 and wr_addr=rsv_addr)); otherwise 0.
REQ-024 Busy update per edge: a write to a register clears its bit; an accepted reservation sets its bit; when both target the same register, set wins (bit stays 1).
REQ-025 A rejected reservation (rsv_en=1, rsv_ok=0) SHALL leave all state unchanged; the requester retries.
REQ-026 A write to a non-busy register SHALL update data and leave busy bits unchanged.
REQ-027 busy_count SHALL equal the population count of the busy vector after each edge; range 0..NUM_REGS, no wrap.
REQ-028 Write and reservation to different registers in one cycle SHALL both take effect.

Reset
REQ-029 On a rising edge with rst_n=0: all registers SHALL become 0 except array[SP_REG] = SP_INIT; busy vector = 0; busy_count = 0.
REQ-030 Reset SHALL override any concurrent wr_en or rsv_en in that cycle (write and reservation discarded).
REQ-031 While rst_n=0, rsv_ok SHALL be 0 and no bypass forwarding SHALL occur; reads return current array contents.

Verification
REQ-032 Reset, then read rs=31, rt=0, rd=5 -> rs_data=64'h80000, rt_data=0, rd_data=0, busy_count=0.
REQ-033 Write r1=64'h0123_4567_89AB_CDEF, same cycle rs_addr=1 -> rs_data=write value (BYPASS=1); next cycle r1 reads same value with wr_en=0; BYPASS=0 build shows 0 in write cycle.
REQ-034 rsv r3 -> rsv_ok=1, next cycle busy_rs(rs=3)=1, busy_count=1; rsv r3 again -> rsv_ok=0, busy_count stays 1.
REQ-035 r3 busy; same cycle wr r3=64'hAA and rsv r3 -> rsv_ok=1, r3 reads 64'hAA, busy stays 1, busy_count=1.
REQ-036 Reserve r2, r4, r6 over three cycles (busy_count 1,2,3); write r4 and rsv r7 in one cycle -> busy_count=3, busy_rt(rt=4)=0.
REQ-037 With r5 busy and holding 64'h55, assert rst_n=0 with wr_en=1 to r5=64'h99 -> after edge r5=0, busy_count=0, r31=64'h80000.
